cdma_wt_grp_fetch_ctrl: RTL
===========================

Name: cdma_wt_grp_fetch_ctrl

Overview:
Read-side sequencer for the CDMA weight-group-size FIFO.
- Pops one 32-bit group size (in atoms) per kernel group.
- Splits each group into atom-aligned DMA read requests that never cross a MAX_BURST-atom address boundary.
- Gates issue on a CBUF free-space credit counter.
- Sits between the wgs FIFO read port and the CDMA weight DMA request arbiter.

Parameters:
ADDR_W, 64, DMA byte-address width
ATOM_BYTES, 32, bytes per atom; addresses are atom-aligned
MAX_BURST, 8, max atoms per DMA request (power of 2)
BUF_ATOMS, 16384, CBUF weight-space capacity in atoms; credit counter reset/start value
CRED_W, 15, credit counter width (holds 0..BUF_ATOMS)
GRP_W, 12, group-count width

Ports:
clk  in  1  clock
reset_  in  1  asynchronous, active-low reset
cfg_start  in  1  one-cycle layer start pulse; ignored while busy
cfg_base_addr  in  ADDR_W  layer weight base byte address, atom-aligned
cfg_grp_num  in  GRP_W  number of groups minus 1
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when all groups have been issued
wgs_req  in  1  FIFO rd_req (entry valid)
wgs_ready  out  1  FIFO rd_ready (pop)
wgs_data  in  32  group size in atoms
dma_req_valid  out  1  DMA request valid
dma_req_ready  in  1  DMA request accept
dma_req_addr  out  ADDR_W  request byte address
dma_req_size  out  clog2(MAX_BURST)  atoms minus 1
cbuf_free_en  in  1  CBUF released space this cycle
cbuf_free_atoms  in  CRED_W  atoms released
grp_end  out  1  pulse: last request of the current group accepted, or zero-size group consumed

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; credit=BUF_ATOMS; address, remaining and group counters 0.
- FSM states: IDLE, LOAD, ISSUE, DONE.
- IDLE:
  - cfg_start -> LOAD; latch cfg_base_addr into cur_addr and cfg_grp_num into grp_left.
  - credit is not reinitialised; it persists across layers.
- LOAD:
  - wgs_ready=1.
  - On wgs_req&&wgs_ready: capture remaining=wgs_data.
  - Nonzero size -> ISSUE on the next cycle.
  - Zero size -> grp_end pulses in the same cycle, no DMA, and the group is treated as finished (see group finish).
- ISSUE:
  - burst = min(MAX_BURST, remaining, MAX_BURST − cur_addr atom index mod MAX_BURST).
  - dma_req_valid = (credit >= burst).
  - Once valid is high, valid, addr and size are held stable until accepted. Credit only decrements on accept, so valid never retracts.
  - On accept: cur_addr += burst×ATOM_BYTES; remaining −= burst; credit −= burst.
  - Accept with remaining==burst: grp_end pulses and the group is finished.
- Group finish (nonzero or zero-size group): grp_left==0 -> DONE; otherwise grp_left −= 1 and -> LOAD.
- Addressing: cur_addr continues across groups; groups are contiguous in memory.
- DONE: done=1 for one cycle, then -> IDLE. busy=0 in IDLE, 1 in LOAD, ISSUE and DONE.
- Credit update on simultaneous accept and cbuf_free_en: credit += cbuf_free_atoms − burst in one cycle.
  - Credit exceeding BUF_ATOMS is a protocol error: assertion, result saturates at BUF_ATOMS.
- Latency:
  - FIFO pop to first dma_req_valid: 1 cycle, given sufficient credit.
  - Back-to-back accepts: one request per cycle.
- cur_addr wraps modulo 2^ADDR_W with no error.
- Reset asserted mid-operation: immediate return to reset state. Partially issued groups are abandoned; the FIFO and CBUF must be reset together.
- wgs_data bits above the remaining-counter width (32) are not truncated; the remaining counter is 32 bits.

Decomposition:
- Shared package cdma_wt_pkg holds:
  - FSM state encoding
  - ATOM_BYTES / MAX_BURST defaults
  - the burst-size function: min of remaining, boundary distance and MAX_BURST
- One natural sub-module: cdma_wt_credit_cnt (credit counter with add/sub/saturate and overflow assert).

Test Plan:
1. Start with base 0x1000, grp_num=0, FIFO entry 20 atoms, full credit -> requests (0x1000, size 7), (0x1100, size 7), (0x1200, size 3); grp_end on the 3rd accept; done 1 cycle later.
2. Base 0x10A0 (atom index 5), group of 8 -> requests (0x10A0, size 2), (0x1100, size 4); boundary is never crossed.
3. Credit forced to 4, group of 8 -> valid stays low. Then cbuf_free_en with 4 atoms -> valid rises the next cycle with size 7; credit reaches 0 after accept.
4. grp_num=2 with entries 0, 3, 0 -> three grp_end pulses; a single request of size 2; done after the third entry.
5. dma_req_ready held low 10 cycles -> addr, size and valid unchanged throughout. A simultaneous free of 8 with an accept of 8 leaves credit unchanged.
6. reset_ asserted mid-group, after 1 of 3 requests -> outputs 0, credit=BUF_ATOMS; a new cfg_start restarts cleanly from the new base.

Source files
------------

// File: rtl/cdma_wt_pkg.sv
// Shared definitions for the CDMA weight fetch path: FSM encoding, default
// geometry and the burst-size helper.
package cdma_wt_pkg;

  localparam int unsigned CDMA_ATOM_BYTES = 32;
  localparam int unsigned CDMA_MAX_BURST  = 8;
  localparam int unsigned CDMA_BUF_ATOMS  = 16384;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } wt_state_e;

  // Atoms in the next request: limited by the burst cap, the distance to the
  // next MAX_BURST-aligned boundary and what is left in the group.
  function automatic int unsigned burst_size(input logic [31:0] remaining,
                                             input int unsigned bound_dist,
                                             input int unsigned max_burst);
    int unsigned b;
    b = max_burst;
    if (bound_dist < b) b = bound_dist;
    if (remaining < b) b = remaining;
    return b;
  endfunction

endpackage

// File: rtl/cdma_wt_grp_fetch_ctrl_if.sv
// wgs FIFO read port and DMA request port of the weight group fetch sequencer.
interface cdma_wt_grp_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned SIZE_W = 3
);
  logic              wgs_req;
  logic              wgs_ready;
  logic [31:0]       wgs_data;
  logic              dma_req_valid;
  logic              dma_req_ready;
  logic [ADDR_W-1:0] dma_req_addr;
  logic [SIZE_W-1:0] dma_req_size;

  modport master (
    input  wgs_req, wgs_data, dma_req_ready,
    output wgs_ready, dma_req_valid, dma_req_addr, dma_req_size
  );

  modport slave (
    output wgs_req, wgs_data, dma_req_ready,
    input  wgs_ready, dma_req_valid, dma_req_addr, dma_req_size
  );
endinterface

// File: rtl/cdma_wt_credit_cnt.sv
// CBUF free-space credit counter: add on release, subtract on DMA accept,
// saturating at the buffer capacity.
module cdma_wt_credit_cnt #(
  parameter int unsigned CRED_W    = 15,
  parameter int unsigned BUF_ATOMS = 16384
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              add_en,
  input  logic [CRED_W-1:0] add_atoms,
  input  logic              sub_en,
  input  logic [CRED_W-1:0] sub_atoms,
  output logic [CRED_W-1:0] credit
);

  localparam int unsigned SUM_W = CRED_W + 2;

  logic [SUM_W-1:0] sum;
  logic             overflow;

  always_comb begin
    sum = SUM_W'(credit);
    if (add_en) sum = sum + SUM_W'(add_atoms);
    if (sub_en) sum = sum - SUM_W'(sub_atoms);
    overflow = (sum > SUM_W'(BUF_ATOMS));
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      credit <= CRED_W'(BUF_ATOMS);
    end else if (add_en || sub_en) begin
      credit <= overflow ? CRED_W'(BUF_ATOMS) : sum[CRED_W-1:0];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_) !overflow);

endmodule

// File: rtl/cdma_wt_grp_fetch_ctrl.sv
// Pops group sizes from the wgs FIFO and splits each group into atom-aligned,
// boundary-respecting DMA read requests gated by CBUF credit.
module cdma_wt_grp_fetch_ctrl
  import cdma_wt_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned ATOM_BYTES = CDMA_ATOM_BYTES,
  parameter int unsigned MAX_BURST  = CDMA_MAX_BURST,
  parameter int unsigned BUF_ATOMS  = CDMA_BUF_ATOMS,
  parameter int unsigned CRED_W     = 15,
  parameter int unsigned GRP_W      = 12
) (
  input  logic                        clk,
  input  logic                        reset_,
  input  logic                        cfg_start,
  input  logic [ADDR_W-1:0]           cfg_base_addr,
  input  logic [GRP_W-1:0]            cfg_grp_num,
  output logic                        busy,
  output logic                        done,
  input  logic                        cbuf_free_en,
  input  logic [CRED_W-1:0]           cbuf_free_atoms,
  output logic                        grp_end,
  cdma_wt_grp_fetch_ctrl_if.master    bus
);

  localparam int unsigned ATOM_SH = $clog2(ATOM_BYTES);
  localparam int unsigned IDX_W   = $clog2(MAX_BURST);
  localparam int unsigned SIZE_W  = IDX_W;
  localparam int unsigned BURST_W = IDX_W + 1;

  wt_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [31:0]        remaining_q, remaining_d;
  logic [GRP_W-1:0]   grp_left_q, grp_left_d;

  logic [CRED_W-1:0]  credit;
  logic [IDX_W-1:0]   atom_idx;
  logic [BURST_W-1:0] burst;
  logic               credit_ok;
  logic               accept;
  logic               finish;
  logic               wgs_ready_c;
  logic               valid_c;
  logic               grp_end_c;
  logic               done_c;

  assign atom_idx  = cur_addr_q[ATOM_SH +: IDX_W];
  assign burst     = BURST_W'(burst_size(remaining_q, MAX_BURST - 32'(atom_idx), MAX_BURST));
  assign credit_ok = (credit >= CRED_W'(burst));
  assign accept    = valid_c && bus.dma_req_ready;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    grp_left_d  = grp_left_q;
    wgs_ready_c = 1'b0;
    valid_c     = 1'b0;
    grp_end_c   = 1'b0;
    done_c      = 1'b0;
    finish      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d    = ST_LOAD;
          cur_addr_d = cfg_base_addr;
          grp_left_d = cfg_grp_num;
        end
      end
      ST_LOAD: begin
        wgs_ready_c = 1'b1;
        if (bus.wgs_req) begin
          remaining_d = bus.wgs_data;
          if (bus.wgs_data != '0) begin
            state_d = ST_ISSUE;
          end else begin
            grp_end_c = 1'b1;
            finish    = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        // Credit only grows while waiting, so valid never drops before accept.
        valid_c = credit_ok;
        if (credit_ok && bus.dma_req_ready) begin
          cur_addr_d  = cur_addr_q + (ADDR_W'(burst) << ATOM_SH);
          remaining_d = remaining_q - 32'(burst);
          if (remaining_q == 32'(burst)) begin
            grp_end_c = 1'b1;
            finish    = 1'b1;
          end
        end
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (finish) begin
      if (grp_left_q == '0) begin
        state_d = ST_DONE;
      end else begin
        grp_left_d = grp_left_q - GRP_W'(1);
        state_d    = ST_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      grp_left_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      grp_left_q  <= grp_left_d;
    end
  end

  cdma_wt_credit_cnt #(
    .CRED_W   (CRED_W),
    .BUF_ATOMS(BUF_ATOMS)
  ) u_credit (
    .clk      (clk),
    .reset_   (reset_),
    .add_en   (cbuf_free_en),
    .add_atoms(cbuf_free_atoms),
    .sub_en   (accept),
    .sub_atoms(CRED_W'(burst)),
    .credit   (credit)
  );

  assign busy              = (state_q != ST_IDLE);
  assign done              = done_c;
  assign grp_end           = grp_end_c;
  assign bus.wgs_ready     = wgs_ready_c;
  assign bus.dma_req_valid = valid_c;
  assign bus.dma_req_addr  = cur_addr_q;
  assign bus.dma_req_size  = (state_q == ST_ISSUE) ? SIZE_W'(burst - BURST_W'(1)) : '0;

endmodule
